ldr_ram_writer: RTL and testbench

LDR_RAM_WRITER -- requirements
Module: ldr_ram_writer

---
 rtl/ldr_ram_writer_if.sv | 30 +++
 rtl/ldr_ram_writer.sv | 125 ++++++++++++
 tb/tb_ldr_ram_writer.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ldr_ram_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : ldr_ram_writer_if
// Description : Loader byte handshake plus 16-bit RAM write port.
// Revision    : 1.0 - initial release
// ============================================================================
interface ldr_ram_writer_if;
  logic        ldr_aen;
  logic [19:0] ldr_addr;
  logic [7:0]  ldr_wdat;
  logic        ldr_wr;
  logic        ldr_ack;
  logic        ram_req;
  logic        ram_ack;
  logic [22:0] ram_addr;
  logic [15:0] ram_wdat;
  logic [1:0]  ram_be;
  logic        ldr_fin;

  // slave: the writer block; master: loader and RAM side
  modport slave (
    input  ldr_aen, ldr_addr, ldr_wdat, ldr_wr, ram_ack,
    output ldr_ack, ram_req, ram_addr, ram_wdat, ram_be, ldr_fin
  );
  modport master (
    output ldr_aen, ldr_addr, ldr_wdat, ldr_wr, ram_ack,
    input  ldr_ack, ram_req, ram_addr, ram_wdat, ram_be, ldr_fin
  );
endinterface
`default_nettype wire

// File: rtl/ldr_ram_writer.sv
`default_nettype none
// ============================================================================
// Module      : ldr_ram_writer
// Description : Packs loader bytes into 16-bit RAM writes, merging even/odd
//               byte pairs of the same word into a single access.
// Revision    : 1.0 - initial release
// ============================================================================
module ldr_ram_writer #(
  parameter logic [23:0] RAM_BASE = 24'hF00000
) (
  input  wire logic       sysclk,
  input  wire logic       rstn,
  ldr_ram_writer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HOLD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_ACKW  = 3'd3,
    ST_FLUSH = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [22:0] r_addr,  w_addr_nxt;
  logic [15:0] r_wdat,  w_wdat_nxt;
  logic [1:0]  r_be,    w_be_nxt;
  logic        r_pend,  w_pend_nxt;
  logic        r_aen_q;
  logic [23:0] w_byte_addr;

  assign w_byte_addr = RAM_BASE + {4'h0, bus.ldr_addr};

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_wdat  <= '0;
      r_be    <= '0;
      r_pend  <= 1'b0;
      r_aen_q <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_wdat  <= w_wdat_nxt;
      r_be    <= w_be_nxt;
      r_pend  <= w_pend_nxt;
      r_aen_q <= bus.ldr_aen;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_wdat_nxt  = r_wdat;
    w_be_nxt    = r_be;
    w_pend_nxt  = r_pend;
    case (r_state)
      ST_IDLE: begin
        if (!bus.ldr_aen) begin
          w_state_nxt = ST_FIN;
        end else if (bus.ldr_wr) begin
          w_addr_nxt = w_byte_addr[23:1];
          if (w_byte_addr[0]) begin
            w_wdat_nxt[7:0] = bus.ldr_wdat;
            w_be_nxt        = 2'b01;
            w_pend_nxt      = 1'b0;
            w_state_nxt     = ST_WRITE;
          end else begin
            // Even byte is acked now and only written once its partner or a flush arrives
            w_wdat_nxt[15:8] = bus.ldr_wdat;
            w_pend_nxt       = 1'b1;
            w_state_nxt      = ST_ACKW;
          end
        end
      end
      ST_HOLD: begin
        if (!bus.ldr_aen) begin
          w_be_nxt    = 2'b10;
          w_state_nxt = ST_FLUSH;
        end else if (bus.ldr_wr) begin
          if (w_byte_addr[23:1] != r_addr) begin
            // New byte stays unacked; IDLE picks it up after the flush
            w_be_nxt    = 2'b10;
            w_state_nxt = ST_FLUSH;
          end else if (w_byte_addr[0]) begin
            w_wdat_nxt[7:0] = bus.ldr_wdat;
            w_be_nxt        = 2'b11;
            w_pend_nxt      = 1'b0;
            w_state_nxt     = ST_WRITE;
          end else begin
            w_wdat_nxt[15:8] = bus.ldr_wdat;
            w_state_nxt      = ST_ACKW;
          end
        end
      end
      ST_WRITE: begin
        if (bus.ram_ack) w_state_nxt = ST_ACKW;
      end
      ST_FLUSH: begin
        if (bus.ram_ack) begin
          w_pend_nxt  = 1'b0;
          w_state_nxt = bus.ldr_aen ? ST_IDLE : ST_FIN;
        end
      end
      ST_ACKW: begin
        if (!bus.ldr_wr) w_state_nxt = r_pend ? ST_HOLD : ST_IDLE;
      end
      ST_FIN: begin
        if (bus.ldr_aen && !r_aen_q) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.ldr_ack  = (r_state == ST_ACKW);
  assign bus.ram_req  = (r_state == ST_WRITE) || (r_state == ST_FLUSH);
  assign bus.ldr_fin  = (r_state == ST_FIN);
  assign bus.ram_addr = r_addr;
  assign bus.ram_wdat = r_wdat;
  assign bus.ram_be   = r_be;

endmodule
`default_nettype wire

// File: tb/tb_ldr_ram_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ldr_ram_writer
// Description : Self-checking bench for ldr_ram_writer with a RAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ldr_ram_writer;

  localparam logic [23:0] RAM_BASE = 24'hF00000;

  typedef struct packed {
    logic [22:0] addr;
    logic [15:0] wdat;
    logic [1:0]  be;
  } wr_t;

  logic sysclk = 1'b0;
  logic rstn   = 1'b1;
  always #5 sysclk = ~sysclk;

  ldr_ram_writer_if bus ();
  ldr_ram_writer #(.RAM_BASE(RAM_BASE)) dut (.sysclk(sysclk), .rstn(rstn), .bus(bus));

  int   checks    = 0;
  int   errors    = 0;
  int   ack_cnt   = 0;
  int   ack_delay = 0;
  int   wait_cnt  = 0;
  logic ack_prev  = 1'b0;
  wr_t  wlog[$];

  // RAM responder: one-cycle ram_ack after ack_delay cycles of ram_req
  initial begin
    wr_t e;
    bus.ram_ack = 1'b0;
    forever begin
      @(negedge sysclk);
      if (!rstn || bus.ram_ack) begin
        bus.ram_ack = 1'b0;
        wait_cnt    = 0;
      end else if (bus.ram_req) begin
        if (wait_cnt >= ack_delay) begin
          bus.ram_ack = 1'b1;
          e.addr = bus.ram_addr; e.wdat = bus.ram_wdat; e.be = bus.ram_be;
          wlog.push_back(e);
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge sysclk);
      if (bus.ldr_ack === 1'b1 && ack_prev !== 1'b1) ack_cnt++;
      ack_prev = bus.ldr_ack;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [19:0] a, input logic [7:0] d, output int wr_at_ack);
    int n;
    @(negedge sysclk);
    bus.ldr_addr = a; bus.ldr_wdat = d; bus.ldr_wr = 1'b1;
    n = 0;
    while (bus.ldr_ack !== 1'b1 && n < 300) begin @(negedge sysclk); n++; end
    wr_at_ack = wlog.size();
    checks++;
    if (n >= 300) begin errors++; $display("FAIL ack_wait addr=%h got ldr_ack=%b want=1", a, bus.ldr_ack); end
    bus.ldr_wr = 1'b0;
    n = 0;
    while (bus.ldr_ack !== 1'b0 && n < 300) begin @(negedge sysclk); n++; end
    checks++;
    if (n >= 300) begin errors++; $display("FAIL ack_release addr=%h got ldr_ack=%b want=0", a, bus.ldr_ack); end
  endtask

  task automatic start_session();
    @(negedge sysclk);
    bus.ldr_aen = 1'b1;
    repeat (2) @(negedge sysclk);
  endtask

  task automatic end_session();
    int n;
    @(negedge sysclk);
    bus.ldr_aen = 1'b0;
    n = 0;
    while (bus.ldr_fin !== 1'b1 && n < 300) begin @(negedge sysclk); n++; end
    checks++;
    if (bus.ldr_fin !== 1'b1) begin errors++; $display("FAIL fin got=%b want=1", bus.ldr_fin); end
  endtask

  task automatic test_reset();
    bus.ldr_aen = 1'b0; bus.ldr_addr = '0; bus.ldr_wdat = '0; bus.ldr_wr = 1'b0;
    #2 rstn = 1'b0;
    repeat (2) @(negedge sysclk);
    checks++; if (bus.ldr_ack  !== 1'b0)  begin errors++; $display("FAIL rst_ldr_ack got=%b want=0", bus.ldr_ack); end
    checks++; if (bus.ram_req  !== 1'b0)  begin errors++; $display("FAIL rst_ram_req got=%b want=0", bus.ram_req); end
    checks++; if (bus.ram_be   !== 2'b00) begin errors++; $display("FAIL rst_ram_be got=%b want=00", bus.ram_be); end
    checks++; if (bus.ram_wdat !== 16'h0) begin errors++; $display("FAIL rst_ram_wdat got=%h want=0", bus.ram_wdat); end
    checks++; if (bus.ram_addr !== 23'h0) begin errors++; $display("FAIL rst_ram_addr got=%h want=0", bus.ram_addr); end
    checks++; if (bus.ldr_fin  !== 1'b0)  begin errors++; $display("FAIL rst_ldr_fin got=%b want=0", bus.ldr_fin); end
    rstn = 1'b1;
    repeat (2) @(negedge sysclk);
  endtask

  task automatic test_pair();
    int w, a0;
    wlog.delete(); a0 = ack_cnt;
    start_session();
    send_byte(20'd0, 8'h12, w);
    send_byte(20'd1, 8'h34, w);
    end_session();
    checks++; if (wlog.size() != 1) begin errors++; $display("FAIL pair_count got=%0d want=1", wlog.size()); end
    if (wlog.size() >= 1) begin
      checks++; if (wlog[0].addr !== 23'h780000) begin errors++; $display("FAIL pair_addr got=%h want=780000", wlog[0].addr); end
      checks++; if (wlog[0].wdat !== 16'h1234)   begin errors++; $display("FAIL pair_wdat got=%h want=1234", wlog[0].wdat); end
      checks++; if (wlog[0].be   !== 2'b11)      begin errors++; $display("FAIL pair_be got=%b want=11", wlog[0].be); end
    end
    checks++; if (ack_cnt - a0 != 2) begin errors++; $display("FAIL pair_acks got=%0d want=2", ack_cnt - a0); end
  endtask

  task automatic test_odd_start();
    int w;
    wlog.delete();
    start_session();
    send_byte(20'd5, 8'hAB, w);
    end_session();
    checks++; if (wlog.size() != 1) begin errors++; $display("FAIL odd_count got=%0d want=1", wlog.size()); end
    if (wlog.size() >= 1) begin
      checks++; if (wlog[0].addr !== 23'h780002)  begin errors++; $display("FAIL odd_addr got=%h want=780002", wlog[0].addr); end
      checks++; if (wlog[0].wdat[7:0] !== 8'hAB)  begin errors++; $display("FAIL odd_wdat got=%h want=AB", wlog[0].wdat[7:0]); end
      checks++; if (wlog[0].be   !== 2'b01)       begin errors++; $display("FAIL odd_be got=%b want=01", wlog[0].be); end
    end
  endtask

  task automatic test_trailing_even();
    int w;
    wlog.delete();
    start_session();
    send_byte(20'd6, 8'h55, w);
    checks++; if (w != 0) begin errors++; $display("FAIL even_early_write got=%0d want=0", w); end
    end_session();
    checks++; if (wlog.size() != 1) begin errors++; $display("FAIL even_count got=%0d want=1", wlog.size()); end
    if (wlog.size() >= 1) begin
      checks++; if (wlog[0].addr !== 23'h780003)  begin errors++; $display("FAIL even_addr got=%h want=780003", wlog[0].addr); end
      checks++; if (wlog[0].wdat[15:8] !== 8'h55) begin errors++; $display("FAIL even_wdat got=%h want=55", wlog[0].wdat[15:8]); end
      checks++; if (wlog[0].be   !== 2'b10)       begin errors++; $display("FAIL even_be got=%b want=10", wlog[0].be); end
    end
  endtask

  task automatic test_gap();
    int w1, w2;
    wlog.delete();
    start_session();
    send_byte(20'd0, 8'h11, w1);
    send_byte(20'd4, 8'h22, w2);
    checks++; if (w2 != 1) begin errors++; $display("FAIL gap_flush_before_ack got=%0d want=1", w2); end
    if (wlog.size() >= 1) begin
      checks++;
      if (wlog[0].addr !== 23'h780000 || wlog[0].be !== 2'b10 || wlog[0].wdat[15:8] !== 8'h11) begin
        errors++; $display("FAIL gap_first got=%h/%b/%h want=780000/10/11", wlog[0].addr, wlog[0].be, wlog[0].wdat[15:8]);
      end
    end
    end_session();
    checks++; if (wlog.size() != 2) begin errors++; $display("FAIL gap_count got=%0d want=2", wlog.size()); end
    if (wlog.size() >= 2) begin
      checks++;
      if (wlog[1].addr !== 23'h780002 || wlog[1].be !== 2'b10 || wlog[1].wdat[15:8] !== 8'h22) begin
        errors++; $display("FAIL gap_second got=%h/%b/%h want=780002/10/22", wlog[1].addr, wlog[1].be, wlog[1].wdat[15:8]);
      end
    end
  endtask

  task automatic test_stall();
    int w, n;
    logic [22:0] a; logic [15:0] d; logic [1:0] b;
    wlog.delete();
    start_session();
    send_byte(20'd0, 8'h12, w);
    ack_delay = 20;
    @(negedge sysclk);
    bus.ldr_addr = 20'd1; bus.ldr_wdat = 8'h34; bus.ldr_wr = 1'b1;
    n = 0;
    while (bus.ram_req !== 1'b1 && n < 50) begin @(negedge sysclk); n++; end
    checks++; if (bus.ram_req !== 1'b1) begin errors++; $display("FAIL stall_req got=%b want=1", bus.ram_req); end
    a = bus.ram_addr; d = bus.ram_wdat; b = bus.ram_be;
    for (int i = 0; i < 20; i++) begin
      @(negedge sysclk);
      checks++;
      if (bus.ram_req !== 1'b1 || bus.ram_addr !== a || bus.ram_wdat !== d || bus.ram_be !== b || bus.ldr_ack !== 1'b0) begin
        errors++; $display("FAIL stall_hold cyc=%0d got req=%b ack=%b addr=%h want req=1 ack=0 addr=%h", i, bus.ram_req, bus.ldr_ack, bus.ram_addr, a);
      end
    end
    n = 0;
    while (bus.ldr_ack !== 1'b1 && n < 50) begin @(negedge sysclk); n++; end
    checks++; if (bus.ldr_ack !== 1'b1) begin errors++; $display("FAIL stall_ack got=%b want=1", bus.ldr_ack); end
    bus.ldr_wr = 1'b0;
    ack_delay = 0;
    repeat (3) @(negedge sysclk);
    end_session();
    checks++;
    if (wlog.size() != 1 || a !== 23'h780000 || d !== 16'h1234 || b !== 2'b11) begin
      errors++; $display("FAIL stall_write got n=%0d %h/%h/%b want 1 780000/1234/11", wlog.size(), a, d, b);
    end
  endtask

  task automatic test_aen_guard();
    int a0;
    logic seen_ack, seen_req;
    a0 = ack_cnt; seen_ack = 1'b0; seen_req = 1'b0;
    @(negedge sysclk);
    bus.ldr_addr = 20'd3; bus.ldr_wdat = 8'h77; bus.ldr_wr = 1'b1;
    repeat (10) begin
      @(negedge sysclk);
      if (bus.ldr_ack !== 1'b0) seen_ack = 1'b1;
      if (bus.ram_req !== 1'b0) seen_req = 1'b1;
    end
    bus.ldr_wr = 1'b0;
    checks++; if (seen_ack !== 1'b0) begin errors++; $display("FAIL guard_ack got=%b want=0", seen_ack); end
    checks++; if (seen_req !== 1'b0) begin errors++; $display("FAIL guard_req got=%b want=0", seen_req); end
    checks++; if (ack_cnt != a0)     begin errors++; $display("FAIL guard_ackcnt got=%0d want=%0d", ack_cnt, a0); end
  endtask

  task automatic test_reset_mid_write();
    int n, a0;
    a0 = ack_cnt;
    ack_delay = 50;
    start_session();
    @(negedge sysclk);
    bus.ldr_addr = 20'd1; bus.ldr_wdat = 8'hAB; bus.ldr_wr = 1'b1;
    n = 0;
    while (bus.ram_req !== 1'b1 && n < 50) begin @(negedge sysclk); n++; end
    repeat (3) @(negedge sysclk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({bus.ram_req, bus.ldr_ack, bus.ldr_fin, bus.ram_be, bus.ram_wdat, bus.ram_addr} !== '0) begin
      errors++; $display("FAIL midrst_outputs got req=%b ack=%b be=%b wdat=%h addr=%h want all 0", bus.ram_req, bus.ldr_ack, bus.ram_be, bus.ram_wdat, bus.ram_addr);
    end
    bus.ldr_wr = 1'b0; bus.ldr_aen = 1'b0; ack_delay = 0;
    repeat (2) @(negedge sysclk);
    checks++; if (ack_cnt != a0) begin errors++; $display("FAIL midrst_ack got=%0d want=%0d", ack_cnt - a0, 0); end
    rstn = 1'b1;
    test_pair();
  endtask

  task automatic test_random();
    for (int s = 0; s < 3; s++) begin
      logic [19:0] al[$];
      logic [7:0]  dl[$];
      wr_t         exp_q[$];
      wr_t         e;
      logic [19:0] a;
      logic [23:0] ba;
      logic [15:0] m;
      int          w, a0, nb;
      nb = 24; a0 = ack_cnt;
      wlog.delete();
      ack_delay = $urandom_range(0, 3);
      a = 20'($urandom_range(0, 255));
      for (int i = 0; i < nb; i++) begin
        if (i > 0) begin
          if ($urandom_range(0, 9) < 7) a = a + 20'd1;
          else a = 20'($urandom_range(0, 255));
          if (a == al[i-1]) a = a + 20'd1;
        end
        al.push_back(a);
        dl.push_back(8'($urandom));
      end
      // Reference: odd bytes always write (paired if their even partner came just before);
      // even bytes write alone unless the very next byte is their odd partner.
      for (int i = 0; i < nb; i++) begin
        ba = RAM_BASE + {4'h0, al[i]};
        e.addr = ba[23:1]; e.wdat = 16'h0;
        if (!ba[0]) begin
          if (!(i + 1 < nb && al[i+1] == al[i] + 20'd1)) begin
            e.be = 2'b10; e.wdat[15:8] = dl[i]; exp_q.push_back(e);
          end
        end else if (i > 0 && al[i-1] == al[i] - 20'd1) begin
          e.be = 2'b11; e.wdat = {dl[i-1], dl[i]}; exp_q.push_back(e);
        end else begin
          e.be = 2'b01; e.wdat[7:0] = dl[i]; exp_q.push_back(e);
        end
      end
      start_session();
      for (int i = 0; i < nb; i++) send_byte(al[i], dl[i], w);
      end_session();
      checks++; if (ack_cnt - a0 != nb) begin errors++; $display("FAIL rand_acks s=%0d got=%0d want=%0d", s, ack_cnt - a0, nb); end
      checks++; if (wlog.size() != exp_q.size()) begin errors++; $display("FAIL rand_count s=%0d got=%0d want=%0d", s, wlog.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
        m = {{8{exp_q[i].be[1]}}, {8{exp_q[i].be[0]}}};
        checks++;
        if (wlog[i].addr !== exp_q[i].addr || wlog[i].be !== exp_q[i].be || (wlog[i].wdat & m) !== exp_q[i].wdat) begin
          errors++;
          $display("FAIL rand_write s=%0d i=%0d got=%h/%b/%h want=%h/%b/%h", s, i, wlog[i].addr, wlog[i].be, wlog[i].wdat & m,
                   exp_q[i].addr, exp_q[i].be, exp_q[i].wdat);
        end
      end
    end
    ack_delay = 0;
  endtask

  initial begin
    test_reset();
    test_pair();
    test_odd_start();
    test_trailing_even();
    test_gap();
    test_stall();
    test_aen_guard();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
